// File: rtl/mem_io_bus.sv
// Processor memory/IO decode: RAM, LED reg, synced switches, byte TX FIFO; DIN 1-cycle latency, FIFO drains valid/ready.
// Full FIFO drops pushes (sticky TxOverflow); optional MEM_IO_BUS_ERR_EN adds sticky BusErr on bad writes.
module mem_io_bus #(
    parameter int RAM_AW     = 7,
    parameter int LED_W      = 10,
    parameter int SW_W       = 10,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [15:0]      ADDR,
    input  logic [15:0]      DOUT,
    input  logic             W,
    output logic [15:0]      DIN,
    input  logic [SW_W-1:0]  SW,
    output logic [LED_W-1:0] LEDR,
    output logic [7:0]       TxData,
    output logic             TxValid,
    input  logic             TxReady,
    output logic             TxOverflow
`ifdef MEM_IO_BUS_ERR_EN
    ,
    output logic             BusErr
`endif
);
    localparam int FIFO_AW = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = FIFO_AW + 1;

    logic [15:0]        ram [0:(2**RAM_AW)-1];
    logic [7:0]         fifo_mem [0:FIFO_DEPTH-1];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr, rd_ptr_next;
    logic [CNT_W-1:0]   count, count_next, remaining;
    logic [SW_W-1:0]    sw_meta, sw_sync;
    logic [3:0]         region;
    logic               ram_hit, tx_data_sel, tx_stat_sel, mapped;
    logic               push, pop, full, push_ok, ovf_set;
    logic [7:0]         head_next;
    logic [15:0]        rd_data;

    assign region      = ADDR[15:12];
    assign ram_hit     = (region == 4'h0) && (ADDR[11:RAM_AW] == '0);
    assign tx_data_sel = (region == 4'h2) && !ADDR[0];
    assign tx_stat_sel = (region == 4'h2) && ADDR[0];
    assign mapped      = ram_hit || (region == 4'h1) || (region == 4'h2) || (region == 4'h3);

    assign push        = W && tx_data_sel;
    assign pop         = TxValid && TxReady;
    assign full        = (count == CNT_W'(FIFO_DEPTH));
    assign push_ok     = push && (!full || pop);
    assign ovf_set     = push && full && !pop;
    assign count_next  = count + CNT_W'(push_ok) - CNT_W'(pop);
    assign remaining   = count - CNT_W'(pop);
    assign rd_ptr_next = rd_ptr + FIFO_AW'(pop);

    // Head is registered; when the queue would otherwise be empty the pushed byte becomes the new head.
    always_comb begin
        head_next = TxData;
        if (remaining == '0) begin
            if (push_ok)
                head_next = DOUT[7:0];
        end else begin
            head_next = fifo_mem[rd_ptr_next];
        end
    end

    always_comb begin
        rd_data = '0;
        case (region)
            4'h0: if (ram_hit) rd_data = ram[ADDR[RAM_AW-1:0]];
            4'h1: rd_data = 16'(LEDR);
            4'h2: if (ADDR[0]) rd_data = {TxOverflow, 11'b0, 4'(count)};
            4'h3: rd_data = 16'(sw_sync);
            default: rd_data = '0;
        endcase
    end

    // Storage arrays carry no reset.
    always_ff @(posedge Clock) begin
        if (W && ram_hit)
            ram[ADDR[RAM_AW-1:0]] <= DOUT;
        if (push_ok)
            fifo_mem[wr_ptr] <= DOUT[7:0];
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            DIN        <= '0;
            LEDR       <= '0;
            sw_meta    <= '0;
            sw_sync    <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            TxData     <= '0;
            TxValid    <= 1'b0;
            TxOverflow <= 1'b0;
        end else begin
            DIN     <= rd_data;
            sw_meta <= SW;
            sw_sync <= sw_meta;
            if (W && (region == 4'h1))
                LEDR <= DOUT[LED_W-1:0];
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            rd_ptr  <= rd_ptr_next;
            count   <= count_next;
            TxData  <= head_next;
            TxValid <= (count_next != '0);
            // A fresh overflow outranks the clear from a status read.
            if (ovf_set)
                TxOverflow <= 1'b1;
            else if (tx_stat_sel)
                TxOverflow <= 1'b0;
        end
    end

`ifdef MEM_IO_BUS_ERR_EN
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset)
            BusErr <= 1'b0;
        else if (W && (!mapped || (region == 4'h3) || tx_stat_sel))
            BusErr <= 1'b1;
    end
`else
    logic unused_mapped;
    assign unused_mapped = mapped;
`endif
endmodule

// File: tb/tb_mem_io_bus.sv
// Directed bench for mem_io_bus: DIN and TX drain expectations go through scoreboard queues checked by monitors.
module tb_mem_io_bus;
    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic [15:0] ADDR  = 16'h4000;
    logic [15:0] DOUT  = 16'h0000;
    logic        W     = 1'b0;
    logic [15:0] DIN;
    logic [9:0]  SW    = 10'h000;
    logic [9:0]  LEDR;
    logic [7:0]  TxData;
    logic        TxValid;
    logic        TxReady = 1'b0;
    logic        TxOverflow;
`ifdef MEM_IO_BUS_ERR_EN
    logic        BusErr;
`endif

    mem_io_bus dut (
        .Clock(Clock), .Reset(Reset), .ADDR(ADDR), .DOUT(DOUT), .W(W), .DIN(DIN),
        .SW(SW), .LEDR(LEDR), .TxData(TxData), .TxValid(TxValid), .TxReady(TxReady),
        .TxOverflow(TxOverflow)
`ifdef MEM_IO_BUS_ERR_EN
        , .BusErr(BusErr)
`endif
    );

    always #5 Clock = ~Clock;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [15:0] din_q [$];
    string       name_q [$];
    logic [7:0]  tx_q [$];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
    endtask

    // One bus cycle; expected DIN for this address is queued once the DUT has sampled it.
    task automatic cyc(input logic [15:0] a, input logic [15:0] d, input logic w,
                       input logic chk_en, input logic [15:0] exp, input string name);
        ADDR = a; DOUT = d; W = w;
        @(posedge Clock); #1;
        if (chk_en) begin
            din_q.push_back(exp);
            name_q.push_back(name);
        end
        W = 1'b0;
    endtask

    always @(negedge Clock) begin
        if (din_q.size() > 0) check(name_q.pop_front(), DIN, din_q.pop_front());
    end

    always @(negedge Clock) begin
        if (!Reset && TxValid && TxReady) begin
            if (tx_q.size() == 0) check("tx_unexpected", 16'(TxData), 16'hFFFF);
            else check("tx_drain", 16'(TxData), 16'(tx_q.pop_front()));
        end
    end

    initial begin
        #2;
        check("rst_din", DIN, 16'h0);
        check("rst_led", 16'(LEDR), 16'h0);
        check("rst_txv", 16'(TxValid), 16'h0);
        check("rst_txd", 16'(TxData), 16'h0);
        check("rst_ovf", 16'(TxOverflow), 16'h0);
`ifdef MEM_IO_BUS_ERR_EN
        check("rst_buserr", 16'(BusErr), 16'h0);
`endif
        @(posedge Clock); #1;
        Reset = 1'b0;

        // RAM write/read, read-before-write, aliasing and top word
        cyc(16'h0005, 16'hBEEF, 1'b1, 1'b0, 16'h0,    "");
        cyc(16'h0005, 16'h0000, 1'b0, 1'b1, 16'hBEEF, "ram_rd");
        cyc(16'h0005, 16'h1234, 1'b1, 1'b1, 16'hBEEF, "ram_rbw_old");
        cyc(16'h0005, 16'h0000, 1'b0, 1'b1, 16'h1234, "ram_rbw_new");
        cyc(16'h0085, 16'hAAAA, 1'b1, 1'b0, 16'h0,    "");
        cyc(16'h0005, 16'h0000, 1'b0, 1'b1, 16'h1234, "ram_no_alias");
        cyc(16'h0085, 16'h0000, 1'b0, 1'b1, 16'h0000, "ram_unmapped_rd");
        cyc(16'h007F, 16'h5A5A, 1'b1, 1'b0, 16'h0,    "");
        cyc(16'h007F, 16'h0000, 1'b0, 1'b1, 16'h5A5A, "ram_top_word");

        // LED register
        cyc(16'h1000, 16'h03FF, 1'b1, 1'b0, 16'h0,    "");
        check("led_val", 16'(LEDR), 16'h03FF);
        cyc(16'h1000, 16'h0000, 1'b0, 1'b1, 16'h03FF, "led_rd");
        cyc(16'h1000, 16'hFC12, 1'b1, 1'b0, 16'h0,    "");
        cyc(16'h1000, 16'h0000, 1'b0, 1'b1, 16'h0012, "led_trunc_rd");
        check("led_trunc", 16'(LEDR), 16'h0012);
`ifdef MEM_IO_BUS_ERR_EN
        check("buserr_clean", 16'(BusErr), 16'h0);
`endif

        // TX FIFO fill past full with drain stalled
        for (int i = 0; i < 5; i++) begin
            cyc(16'h2000, 16'(8'h41 + i), 1'b1, 1'b0, 16'h0, "");
            if (i < 4) tx_q.push_back(8'(8'h41 + i));
        end
        check("tx_ovf_set", 16'(TxOverflow), 16'h1);
        check("tx_head", 16'(TxData), 16'h0041);
        check("tx_valid", 16'(TxValid), 16'h1);
        cyc(16'h2001, 16'h0000, 1'b0, 1'b1, 16'h8004, "tx_status_full");
        check("tx_ovf_clr", 16'(TxOverflow), 16'h0);
        cyc(16'h2000, 16'h0000, 1'b0, 1'b1, 16'h0000, "tx_data_rd");
        cyc(16'h2001, 16'h0099, 1'b1, 1'b1, 16'h0004, "tx_status_after");
        cyc(16'h2001, 16'h0000, 1'b0, 1'b1, 16'h0004, "tx_status_wr_ign");

        // Full FIFO with simultaneous pop and push
        TxReady = 1'b1;
        cyc(16'h2000, 16'h0055, 1'b1, 1'b0, 16'h0, "");
        tx_q.push_back(8'h55);
        cyc(16'h2001, 16'h0000, 1'b0, 1'b1, 16'h0004, "tx_full_pushpop");
        check("tx_no_ovf", 16'(TxOverflow), 16'h0);
        for (int i = 0; i < 50 && tx_q.size() > 0; i++) cyc(16'h4000, 16'h0, 1'b0, 1'b0, 16'h0, "");
        cyc(16'h4000, 16'h0, 1'b0, 1'b0, 16'h0, "");
        check("tx_drained", 16'(tx_q.size()), 16'h0);
        check("tx_empty_valid", 16'(TxValid), 16'h0);

        // Switch synchroniser and unmapped region
        SW = 10'h2A5;
        cyc(16'h4000, 16'h0, 1'b0, 1'b0, 16'h0, "");
        cyc(16'h4000, 16'h0, 1'b0, 1'b0, 16'h0, "");
        cyc(16'h3000, 16'h0000, 1'b0, 1'b1, 16'h02A5, "sw_rd");
        cyc(16'h3000, 16'h0111, 1'b1, 1'b1, 16'h02A5, "sw_wr_ign");
        cyc(16'h5000, 16'hFFFF, 1'b1, 1'b1, 16'h0000, "unmapped_rd");
`ifdef MEM_IO_BUS_ERR_EN
        check("buserr_set", 16'(BusErr), 16'h1);
`endif
        cyc(16'h1000, 16'h0000, 1'b0, 1'b1, 16'h0012, "led_untouched");

        // Reset while a byte is waiting
        TxReady = 1'b0;
        cyc(16'h2000, 16'h0077, 1'b1, 1'b0, 16'h0, "");
        check("pre_rst_valid", 16'(TxValid), 16'h1);
        Reset = 1'b1;
        #1;
        check("arst_valid", 16'(TxValid), 16'h0);
        check("arst_data", 16'(TxData), 16'h0);
        check("arst_led", 16'(LEDR), 16'h0);
        check("arst_din", DIN, 16'h0);
`ifdef MEM_IO_BUS_ERR_EN
        check("arst_buserr", 16'(BusErr), 16'h0);
`endif
        @(posedge Clock); #1;
        Reset = 1'b0;
        cyc(16'h2001, 16'h0000, 1'b0, 1'b1, 16'h0000, "post_rst_status");
        cyc(16'h4000, 16'h0000, 1'b0, 1'b0, 16'h0, "");
        check("post_rst_valid", 16'(TxValid), 16'h0);
        @(posedge Clock); #1;
        check("din_q_empty", 16'(din_q.size()), 16'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
